inst_fetch: RTL

Instruction fetch stage: owns the PC, drives the instruction ROM address, and registers the returned word into the IF/ID pipeline register. It sits directly upstream of the combinational instruction ROM and downstream of the EX-stage branch resolver and the hazard unit. Jumps (opcode 6'b010010) are resolved in IF with zero bubbles. Taken branches arrive late as a redirect, and the block flushes the wrong-path word in IF.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_next_pc.sv | 26 ++
 rtl/inst_fetch.sv | 93 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: opcodes, FSM states and
// the jump-target helper.
package fetch_pkg;

  localparam logic [5:0]  OPC_JUMP = 6'b010010;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  // Pseudo-direct jump: upper nibble of pc+4 glued to the word-aligned index.
  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [31:0] inst);
    return {pc4[31:28], inst[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: redirect target, jump target or pc+4.
module fetch_next_pc
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] rom_inst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] next_pc,
  output logic [31:0] pc4
);

  assign pc4 = pc + 32'd4;

  // Redirect targets are forced word-aligned so pc[1:0] can never go non-zero.
  always_comb begin
    if (redirect) begin
      next_pc = redirect_pc & ~32'h3;
    end else if (rom_inst[31:26] == OPC_JUMP) begin
      next_pc = jump_target(pc4, rom_inst);
    end else begin
      next_pc = pc4;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, BOOT/RUN/STALL
// control and performance counters.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  output logic [31:0]      rom_addr_o,
  input  logic [31:0]      rom_inst_i,
  output logic [31:0]      ifid_inst_o,
  output logic [31:0]      ifid_pc4_o,
  output logic             ifid_valid_o,
  output logic [CNT_W-1:0] cnt_fetch_o,
  output logic [CNT_W-1:0] cnt_flush_o,
  output logic [CNT_W-1:0] cnt_stall_o
);

  state_t      state, state_nxt;
  logic [31:0] pc, next_pc, pc4;
  logic        do_redirect, do_stall, do_fetch;

  fetch_next_pc u_next_pc (
    .pc          (pc),
    .rom_inst    (rom_inst_i),
    .redirect    (redirect_i),
    .redirect_pc (redirect_pc_i),
    .next_pc     (next_pc),
    .pc4         (pc4)
  );

  assign rom_addr_o = pc;

  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    state_nxt   = state;
    do_redirect = 1'b0;
    do_stall    = 1'b0;
    do_fetch    = 1'b0;

    // The branch in EX is older than anything stalled in IF, so redirect wins.
    if (state != BOOT) begin
      if (redirect_i)   do_redirect = 1'b1;
      else if (stall_i) do_stall    = 1'b1;
      else              do_fetch    = 1'b1;
    end

    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (do_stall)  state_nxt = STALL;
      STALL:   if (!do_stall) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      ifid_inst_o  <= NOP_INST;
      ifid_pc4_o   <= 32'd0;
      ifid_valid_o <= 1'b0;
      cnt_fetch_o  <= '0;
      cnt_flush_o  <= '0;
      cnt_stall_o  <= '0;
    end else begin
      state <= state_nxt;
      if (do_redirect) begin
        pc           <= next_pc;
        ifid_inst_o  <= NOP_INST;
        ifid_pc4_o   <= 32'd0;
        ifid_valid_o <= 1'b0;
        cnt_flush_o  <= cnt_flush_o + CNT_W'(1);
      end else if (do_stall) begin
        cnt_stall_o  <= cnt_stall_o + CNT_W'(1);
      end else if (do_fetch) begin
        pc           <= next_pc;
        ifid_inst_o  <= rom_inst_i;
        ifid_pc4_o   <= pc4;
        ifid_valid_o <= 1'b1;
        cnt_fetch_o  <= cnt_fetch_o + CNT_W'(1);
      end
    end
  end

endmodule
